// File: rtl/wm_pkg.sv
// Shared types and default constants for the washing-machine plant model.
package wm_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        AGITATE = 2'd1,
        SPIN    = 2'd2
    } drum_t;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_DOSING = 2'd1,
        D_DONE   = 2'd2
    } disp_t;

    localparam int FILL_LEVEL_DEF  = 8;
    localparam int DET_CYCLES_DEF  = 4;
    localparam int WASH_CYCLES_DEF = 16;
    localparam int SPIN_CYCLES_DEF = 12;
    localparam int TIMER_W_DEF     = 16;

endpackage

// File: rtl/wm_timer.sv
// Saturating up-counter with enable, synchronous clear and terminal-count flag.
module wm_timer
    import wm_pkg::*;
#(
    parameter int MAX = DET_CYCLES_DEF,
    parameter int W   = TIMER_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count;

    // Count while enabled, hold at MAX, clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX_C)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == MAX_C);

endmodule

// File: rtl/wm_plant_model.sv
// Cycle-accurate washing-machine appliance model: turns controller actuator
// outputs into the sensor inputs the controller waits on.
// Optional fault monitor is built only when WM_PLANT_FAULT_EN is defined;
// otherwise fault is tied low.
module wm_plant_model
    import wm_pkg::*;
#(
    parameter int FILL_LEVEL  = FILL_LEVEL_DEF,
    parameter int DET_CYCLES  = DET_CYCLES_DEF,
    parameter int WASH_CYCLES = WASH_CYCLES_DEF,
    parameter int SPIN_CYCLES = SPIN_CYCLES_DEF,
    parameter int TIMER_W     = TIMER_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                fillvalve_on,
    input  logic                                drainvalve_on,
    input  logic                                motor_on,
    input  logic                                soap_wash,
    input  logic                                water_wash,
    input  logic                                doorlock,
    input  logic                                done,
    output logic                                filled,
    output logic                                drained,
    output logic                                detergent,
    output logic                                cycletime_out,
    output logic                                spintime_out,
    output logic [$clog2(FILL_LEVEL+1)-1:0]     water_level,
    output logic [1:0]                          drum_state,
    output logic                                fault
);

    localparam int             LW   = $clog2(FILL_LEVEL + 1);
    localparam logic [LW-1:0]  FULL = LW'(FILL_LEVEL);

    logic [LW-1:0] level;
    drum_t         drum_q;
    disp_t         disp_q;
    logic          dose_start;
    logic          dose_en;
    logic          dose_tc;
    logic          spin_en;

    // The rinse flag has no effect on the plant; it is only observed.
    logic unused_inputs;
    assign unused_inputs = water_wash;

    // Tank level: one unit per cycle in or out; opposing valves cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (fillvalve_on && !drainvalve_on && (level != FULL)) begin
            level <= level + 1'b1;
        end else if (drainvalve_on && !fillvalve_on && (level != '0)) begin
            level <= level - 1'b1;
        end
    end

    assign filled      = (level == FULL);
    assign drained     = (level == '0);
    assign water_level = level;

    // Drum motion follows motor first, then drain-at-empty means spinning.
    always_ff @(posedge clk) begin
        if (rst) begin
            drum_q <= STOP;
        end else if (motor_on) begin
            drum_q <= AGITATE;
        end else if (drainvalve_on && drained) begin
            drum_q <= SPIN;
        end else begin
            drum_q <= STOP;
        end
    end

    assign drum_state = drum_q;

    // The dosing timer already counts on the entry edge, so the dispenser
    // spends exactly DET_CYCLES cycles in D_DOSING.
    assign dose_start = (disp_q == D_IDLE) && soap_wash && filled && !motor_on;
    assign dose_en    = dose_start || (disp_q == D_DOSING);

    // Detergent dispenser sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= D_IDLE;
        end else begin
            case (disp_q)
                D_IDLE:   if (dose_start) disp_q <= D_DOSING;
                D_DOSING: if (dose_tc) disp_q <= D_DONE;
                D_DONE:   if (done || !doorlock) disp_q <= D_IDLE;
                default:  disp_q <= D_IDLE;
            endcase
        end
    end

    assign detergent = (disp_q == D_DONE);

    wm_timer #(.MAX(DET_CYCLES), .W(TIMER_W)) u_dose_timer (
        .clk (clk),
        .rst (rst),
        .en  (dose_en),
        .clr (!dose_en),
        .tc  (dose_tc)
    );

    wm_timer #(.MAX(WASH_CYCLES), .W(TIMER_W)) u_wash_timer (
        .clk (clk),
        .rst (rst),
        .en  (motor_on),
        .clr (!motor_on),
        .tc  (cycletime_out)
    );

    assign spin_en = (drum_q == SPIN);

    wm_timer #(.MAX(SPIN_CYCLES), .W(TIMER_W)) u_spin_timer (
        .clk (clk),
        .rst (rst),
        .en  (spin_en),
        .clr (!spin_en),
        .tc  (spintime_out)
    );

`ifdef WM_PLANT_FAULT_EN
    logic fault_q;

    // Sticky misuse detector: once set, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if ((fillvalve_on && drainvalve_on) ||
                     (!doorlock && (level != '0)) ||
                     (motor_on && (level == '0)) ||
                     (fillvalve_on && (level == FULL))) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_wm_plant_model.sv
// Self-checking bench for wm_plant_model: vector table driven through a
// scoreboard queue, plus hand-written fill-timing and door-abort sequences.
module tb_wm_plant_model;

`ifdef WM_PLANT_FAULT_EN
    localparam bit FLT = 1'b1;
`else
    localparam bit FLT = 1'b0;
`endif

    typedef struct {
        logic       rst, fill, drain, motor, soap, door, dn;
        int         n;
        logic       f, d, det, cyc, spin;
        logic [3:0] lvl;
        logic [1:0] drum;
        logic       flt;
    } vec_t;

    typedef struct {
        logic       f, d, det, cyc, spin;
        logic [3:0] lvl;
        logic [1:0] drum;
        logic       flt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fillvalve_on = 1'b0, drainvalve_on = 1'b0, motor_on = 1'b0;
    logic soap_wash = 1'b0, water_wash = 1'b0, doorlock = 1'b1, done = 1'b0;
    logic filled, drained, detergent, cycletime_out, spintime_out, fault;
    logic [3:0] water_level;
    logic [1:0] drum_state;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    wm_plant_model #(
        .FILL_LEVEL(8), .DET_CYCLES(4), .WASH_CYCLES(16),
        .SPIN_CYCLES(12), .TIMER_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .fillvalve_on(fillvalve_on), .drainvalve_on(drainvalve_on),
        .motor_on(motor_on), .soap_wash(soap_wash), .water_wash(water_wash),
        .doorlock(doorlock), .done(done),
        .filled(filled), .drained(drained), .detergent(detergent),
        .cycletime_out(cycletime_out), .spintime_out(spintime_out),
        .water_level(water_level), .drum_state(drum_state), .fault(fault)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty actual=0 required=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_filled"},    32'(filled),        32'(e.f));
            chk({tag, "_drained"},   32'(drained),       32'(e.d));
            chk({tag, "_detergent"}, 32'(detergent),     32'(e.det));
            chk({tag, "_cyctime"},   32'(cycletime_out), 32'(e.cyc));
            chk({tag, "_spintime"},  32'(spintime_out),  32'(e.spin));
            chk({tag, "_level"},     32'(water_level),   32'(e.lvl));
            chk({tag, "_drum"},      32'(drum_state),    32'(e.drum));
            chk({tag, "_fault"},     32'(fault),         32'(e.flt & FLT));
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic dr, input logic mo,
                         input logic so, input logic dl, input logic dn_in);
        rst           = r;
        fillvalve_on  = fl;
        drainvalve_on = dr;
        motor_on      = mo;
        soap_wash     = so;
        doorlock      = dl;
        done          = dn_in;
        water_wash    = 1'($urandom_range(0, 1));
    endtask

    task automatic push_exp(input logic f, input logic d, input logic det, input logic cyc,
                            input logic spin, input logic [3:0] lvl, input logic [1:0] drum,
                            input logic flt);
        exp_t e;
        e.f = f; e.d = d; e.det = det; e.cyc = cyc; e.spin = spin;
        e.lvl = lvl; e.drum = drum; e.flt = flt;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst fill drain motor soap door done | n | filled drained det cyc spin lvl drum flt
        tbl.push_back('{1,0,0,0,0,1,0,  2, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,0,1,0,  7, 0,0,0,0,0,7,0,0});
        tbl.push_back('{0,1,0,0,0,1,0,  1, 1,0,0,0,0,8,0,0});
        tbl.push_back('{0,1,0,0,0,1,0,  2, 1,0,0,0,0,8,0,1});
        tbl.push_back('{1,0,0,0,0,1,0,  1, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,0,1,0,  8, 1,0,0,0,0,8,0,0});
        tbl.push_back('{0,0,0,0,1,1,0,  4, 1,0,0,0,0,8,0,0});
        tbl.push_back('{0,0,0,0,1,1,0,  1, 1,0,1,0,0,8,0,0});
        tbl.push_back('{0,0,0,0,1,1,0,  2, 1,0,1,0,0,8,0,0});
        tbl.push_back('{0,0,0,0,1,1,1,  1, 1,0,0,0,0,8,0,0});
        tbl.push_back('{0,0,0,0,0,1,0,  1, 1,0,0,0,0,8,0,0});
        tbl.push_back('{0,0,0,1,0,1,0, 15, 1,0,0,0,0,8,1,0});
        tbl.push_back('{0,0,0,1,0,1,0,  1, 1,0,0,1,0,8,1,0});
        tbl.push_back('{0,0,0,1,0,1,0,  4, 1,0,0,1,0,8,1,0});
        tbl.push_back('{0,0,0,0,0,1,0,  1, 1,0,0,0,0,8,0,0});
        tbl.push_back('{0,0,1,0,0,1,0,  7, 0,0,0,0,0,1,0,0});
        tbl.push_back('{0,0,1,0,0,1,0,  1, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,0,1,0,0,1,0,  1, 0,1,0,0,0,0,2,0});
        tbl.push_back('{0,0,1,0,0,1,0, 11, 0,1,0,0,0,0,2,0});
        tbl.push_back('{0,0,1,0,0,1,0,  1, 0,1,0,0,1,0,2,0});
        tbl.push_back('{0,0,1,0,0,1,0,  3, 0,1,0,0,1,0,2,0});
        tbl.push_back('{0,0,0,0,0,1,0,  1, 0,1,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,0,1,0,  1, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,0,1,0,  3, 0,0,0,0,0,3,0,0});
        tbl.push_back('{0,1,1,0,0,1,0,  3, 0,0,0,0,0,3,0,1});
        tbl.push_back('{1,0,0,0,0,1,0,  1, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,0,1,0,  5, 0,0,0,0,0,5,0,0});
        tbl.push_back('{0,0,0,1,0,1,0,  6, 0,0,0,0,0,5,1,0});
        tbl.push_back('{1,0,0,1,0,1,0,  1, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,1,0,  1, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,0,1,0,  2, 0,0,0,0,0,2,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,  1, 0,0,0,0,0,2,0,1});
        tbl.push_back('{0,0,0,0,0,1,0,  1, 0,0,0,0,0,2,0,1});
        tbl.push_back('{1,0,0,0,0,1,0,  1, 0,1,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,1,0,1,0,  1, 0,1,0,0,0,0,1,1});
        tbl.push_back('{1,0,0,0,0,1,0,  1, 0,1,0,0,0,0,0,0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].fill, tbl[i].drain, tbl[i].motor,
                  tbl[i].soap, tbl[i].door, tbl[i].dn);
            push_exp(tbl[i].f, tbl[i].d, tbl[i].det, tbl[i].cyc, tbl[i].spin,
                     tbl[i].lvl, tbl[i].drum, tbl[i].flt);
            repeat (tbl[i].n) @(posedge clk);
            #1;
            compare_out($sformatf("v%0d", i));
        end

        // Fill timing edge by edge from an empty tank.
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 0, 0, 0, 1, 0);
            push_exp((i == 8), 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 2'd0, 1'b0);
            @(posedge clk);
            #1;
            compare_out($sformatf("fill_e%0d", i));
        end

        // Dose to completion, then unlocking the door drops detergent.
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 1, 1, 0);
            push_exp(1'b1, 1'b0, (i == 5), 1'b0, 1'b0, 4'd8, 2'd0, 1'b0);
            @(posedge clk);
            #1;
            compare_out($sformatf("dose_e%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("door_abort_detergent", 32'(detergent), 32'd0);
        chk("door_abort_fault", 32'(fault), 32'(FLT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
